// File: rtl/cnt14_updn.sv
// 14-bit up/down counter with parallel load, configurable wrap point,
// combinational carry/borrow-out for cascading and a registered terminal-count pulse.
module cnt14_updn #(
  parameter int unsigned MAXVAL = 16383,
  parameter int unsigned INIT   = 0
) (
  input  logic        CK,
  input  logic        CD,
  input  logic        CI,
  input  logic        LD,
  input  logic        UP,
  input  logic [13:0] D,
  output logic [13:0] Q,
  output logic        CO,
  output logic        TC
);

  localparam logic [13:0] MaxV  = 14'(MAXVAL);
  localparam logic [13:0] InitV = 14'(INIT);

  logic [13:0] q_q, q_d;
  logic        tc_q;
  logic        atMax, atZero;

  // Loaded values above MAXVAL count as "at the wrap point" when counting up.
  assign atMax  = (q_q >= MaxV);
  assign atZero = (q_q == 14'd0);

  assign CO = CI & ~LD & ((UP & atMax) | (~UP & atZero));

  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = D;
    end else if (CI) begin
      if (UP) begin
        q_d = atMax ? 14'd0 : q_q + 14'd1;
      end else begin
        q_d = atZero ? MaxV : q_q - 14'd1;
      end
    end
  end

  // TC is simply CO delayed by one edge, so loads never raise it.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      q_q  <= InitV;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= CO;
    end
  end

  assign Q  = q_q;
  assign TC = tc_q;

endmodule

// File: tb/tb_cnt14_updn.sv
// Self-checking bench for cnt14_updn: full-range instance, MAXVAL=9 instance
// and a two-stage cascade, checked against a reference model through scoreboards.
module tb_cnt14_updn;

  typedef struct packed {
    logic [13:0] q;
    logic        tc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // full-range instance
  logic        cd0, ci0, ld0, up0, co0, tc0;
  logic [13:0] d0, q0;
  // MAXVAL=9 instance with nonzero INIT
  logic        cd9, ci9, ld9, up9, co9, tc9;
  logic [13:0] d9, q9;
  // cascade
  logic        cdC, ciC, ldLo, ldHi, coLo, tcLo, coHi, tcHi;
  logic [13:0] dLo, dHi, qLo, qHi;

  cnt14_updn u0 (.CK(clk), .CD(cd0), .CI(ci0), .LD(ld0), .UP(up0), .D(d0), .Q(q0), .CO(co0), .TC(tc0));
  cnt14_updn #(.MAXVAL(9), .INIT(3)) u9 (.CK(clk), .CD(cd9), .CI(ci9), .LD(ld9), .UP(up9), .D(d9), .Q(q9), .CO(co9), .TC(tc9));
  cnt14_updn uLo (.CK(clk), .CD(cdC), .CI(ciC), .LD(ldLo), .UP(1'b1), .D(dLo), .Q(qLo), .CO(coLo), .TC(tcLo));
  cnt14_updn #(.MAXVAL(3)) uHi (.CK(clk), .CD(cdC), .CI(coLo), .LD(ldHi), .UP(1'b1), .D(dHi), .Q(qHi), .CO(coHi), .TC(tcHi));

  exp_t        sb0[$];
  exp_t        sb9[$];
  logic [13:0] m0, m9;
  logic        expCo0, expCo9;
  exp_t        e;

  function automatic logic [13:0] modelNext(input logic [13:0] q, input logic ld, input logic ci,
                                            input logic up, input logic [13:0] d, input int maxv);
    if (ld) return d;
    if (!ci) return q;
    if (up) return (int'(q) >= maxv) ? 14'd0 : q + 14'd1;
    return (q == 14'd0) ? 14'(maxv) : q - 14'd1;
  endfunction

  function automatic logic modelCo(input logic [13:0] q, input logic ld, input logic ci,
                                   input logic up, input int maxv);
    return ci && !ld && ((up && int'(q) >= maxv) || (!up && q == 14'd0));
  endfunction

  task automatic drive0(input logic ld, input logic ci, input logic up, input logic [13:0] d);
    ld0 = ld; ci0 = ci; up0 = up; d0 = d;
    expCo0 = modelCo(m0, ld, ci, up, 16383);
    m0 = modelNext(m0, ld, ci, up, d, 16383);
    sb0.push_back('{q: m0, tc: expCo0});
  endtask

  task automatic drive9(input logic ld, input logic ci, input logic up, input logic [13:0] d);
    ld9 = ld; ci9 = ci; up9 = up; d9 = d;
    expCo9 = modelCo(m9, ld, ci, up, 9);
    m9 = modelNext(m9, ld, ci, up, d, 9);
    sb9.push_back('{q: m9, tc: expCo9});
  endtask

  task automatic test_reset;
    cd0 = 1'b1; cd9 = 1'b1; cdC = 1'b1;
    ld0 = 1'b0; ci0 = 1'b1; up0 = 1'b0; d0 = 14'd0;
    ld9 = 1'b0; ci9 = 1'b0; up9 = 1'b1; d9 = 14'd0;
    ciC = 1'b0; ldLo = 1'b0; ldHi = 1'b0; dLo = 14'd0; dHi = 14'd0;
    #1;
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL reset_q0: got %0d expected 0", q0); else passes++;
    checks++; if (tc0 !== 1'b0) $display("[TB] FAIL reset_tc0: got %b expected 0", tc0); else passes++;
    checks++; if (co0 !== 1'b1) $display("[TB] FAIL reset_co0_from_init: got %b expected 1", co0); else passes++;
    checks++; if (q9 !== 14'd3) $display("[TB] FAIL reset_q9_init: got %0d expected 3", q9); else passes++;
    ld0 = 1'b1; d0 = 14'd55;
    ld9 = 1'b1; d9 = 14'd7;
    @(posedge clk); #1;
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL reset_ignores_load: got %0d expected 0", q0); else passes++;
    checks++; if (q9 !== 14'd3) $display("[TB] FAIL reset_ignores_load9: got %0d expected 3", q9); else passes++;
    @(negedge clk);
    ld0 = 1'b0; ci0 = 1'b0; ld9 = 1'b0;
    cd0 = 1'b0; cd9 = 1'b0; cdC = 1'b0;
    m0 = 14'd0; m9 = 14'd3;
    drive9(1'b0, 1'b1, 1'b1, 14'd0);
    @(posedge clk); #1;
    e = sb9.pop_front();
    checks++; if (q9 !== e.q) $display("[TB] FAIL first_edge_after_reset: got %0d expected %0d", q9, e.q); else passes++;
    @(negedge clk);
  endtask

  task automatic test_down_wrap;
    int tcSeen = 0;
    drive9(1'b1, 1'b0, 1'b0, 14'd7);
    @(posedge clk); #1; e = sb9.pop_front();
    checks++; if (q9 !== e.q) $display("[TB] FAIL down_load7: got %0d expected %0d", q9, e.q); else passes++;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      drive9(1'b0, 1'b1, 1'b0, 14'd0);
      #1;
      checks++; if (co9 !== expCo9) $display("[TB] FAIL down_co step %0d: got %b expected %b", i, co9, expCo9); else passes++;
      @(posedge clk); #1; e = sb9.pop_front();
      if (tc9 === 1'b1) tcSeen++;
      checks++; if (q9 !== e.q) $display("[TB] FAIL down_q step %0d: got %0d expected %0d", i, q9, e.q); else passes++;
      checks++; if (tc9 !== e.tc) $display("[TB] FAIL down_tc step %0d: got %b expected %b", i, tc9, e.tc); else passes++;
      @(negedge clk);
    end
    checks++; if (q9 !== 14'd8) $display("[TB] FAIL down_final: got %0d expected 8", q9); else passes++;
    checks++; if (tcSeen != 1) $display("[TB] FAIL down_tc_count: got %0d expected 1", tcSeen); else passes++;
  endtask

  task automatic test_load_above_max;
    logic [2:0] upTab;
    upTab = 3'b010;
    for (int k = 0; k < 2; k++) begin
      drive9(1'b1, 1'b0, 1'b0, 14'd12);
      @(posedge clk); #1; e = sb9.pop_front();
      checks++; if (q9 !== e.q) $display("[TB] FAIL above_load: got %0d expected %0d", q9, e.q); else passes++;
      @(negedge clk);
      drive9(1'b0, 1'b1, upTab[k+1], 14'd0);
      #1;
      checks++; if (co9 !== expCo9) $display("[TB] FAIL above_co up=%b: got %b expected %b", upTab[k+1], co9, expCo9); else passes++;
      @(posedge clk); #1; e = sb9.pop_front();
      checks++; if (q9 !== e.q) $display("[TB] FAIL above_q up=%b: got %0d expected %0d", upTab[k+1], q9, e.q); else passes++;
      checks++; if (tc9 !== e.tc) $display("[TB] FAIL above_tc up=%b: got %b expected %b", upTab[k+1], tc9, e.tc); else passes++;
      @(negedge clk);
      drive9(1'b0, 1'b0, 1'b0, 14'd0);
      @(posedge clk); #1; e = sb9.pop_front();
      checks++; if (tc9 !== e.tc) $display("[TB] FAIL above_tc_clear: got %b expected %b", tc9, e.tc); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_priority;
    logic [13:0] dTab[4] = '{14'd16383, 14'd100, 14'd0, 14'd0};
    logic        ciTab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        ldTab[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic        upTab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive0(ldTab[i], ciTab[i], upTab[i], dTab[i]);
      #1;
      checks++; if (co0 !== expCo0) $display("[TB] FAIL prio_co %0d: got %b expected %b", i, co0, expCo0); else passes++;
      @(posedge clk); #1; e = sb0.pop_front();
      checks++; if (q0 !== e.q) $display("[TB] FAIL prio_q %0d: got %0d expected %0d", i, q0, e.q); else passes++;
      checks++; if (tc0 !== e.tc) $display("[TB] FAIL prio_tc %0d: got %b expected %b", i, tc0, e.tc); else passes++;
      @(negedge clk);
    end
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL prio_final: got %0d expected 0", q0); else passes++;
  endtask

  task automatic test_direction_change;
    logic [7:0] dirs;
    dirs = 8'b1011_0010;
    drive0(1'b1, 1'b0, 1'b0, 14'd1);
    @(posedge clk); #1; e = sb0.pop_front();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive0(1'b0, 1'b1, dirs[i], 14'd0);
      #1;
      checks++; if (co0 !== expCo0) $display("[TB] FAIL dir_co %0d: got %b expected %b", i, co0, expCo0); else passes++;
      @(posedge clk); #1; e = sb0.pop_front();
      checks++; if (q0 !== e.q) $display("[TB] FAIL dir_q %0d: got %0d expected %0d", i, q0, e.q); else passes++;
      checks++; if (tc0 !== e.tc) $display("[TB] FAIL dir_tc %0d: got %b expected %b", i, tc0, e.tc); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_clear;
    drive0(1'b1, 1'b0, 1'b0, 14'd499);
    @(posedge clk); #1; e = sb0.pop_front();
    @(negedge clk);
    drive0(1'b0, 1'b1, 1'b1, 14'd0);
    @(posedge clk); #1; e = sb0.pop_front();
    checks++; if (q0 !== 14'd500) $display("[TB] FAIL clr_pre_q: got %0d expected 500", q0); else passes++;
    @(negedge clk);
    #2 cd0 = 1'b1;
    #1;
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL clr_async_q: got %0d expected 0", q0); else passes++;
    checks++; if (tc0 !== 1'b0) $display("[TB] FAIL clr_async_tc: got %b expected 0", tc0); else passes++;
    @(posedge clk); #1;
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL clr_held_q: got %0d expected 0", q0); else passes++;
    @(negedge clk);
    cd0 = 1'b0; ci0 = 1'b0;
    m0 = 14'd0;
    for (int i = 0; i < 2; i++) begin
      drive0(1'b0, 1'b0, 1'b1, 14'd0);
      @(posedge clk); #1; e = sb0.pop_front();
      checks++; if (q0 !== e.q) $display("[TB] FAIL clr_hold_q %0d: got %0d expected %0d", i, q0, e.q); else passes++;
      checks++; if (tc0 !== 1'b0) $display("[TB] FAIL clr_hold_tc %0d: got %b expected 0", i, tc0); else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_count_up_full;
    int tcSeen = 0;
    int coErr = 0;
    int qErr = 0;
    for (int i = 0; i < 16384; i++) begin
      drive0(1'b0, 1'b1, 1'b1, 14'd0);
      #1;
      if (co0 !== expCo0) begin
        checks++;
        if (coErr < 4) $display("[TB] FAIL full_co at q=%0d: got %b expected %b", q0, co0, expCo0);
        coErr++;
      end
      @(posedge clk); #1; e = sb0.pop_front();
      if (tc0 === 1'b1) tcSeen++;
      if (q0 !== e.q || tc0 !== e.tc) begin
        checks++;
        if (qErr < 4) $display("[TB] FAIL full_step %0d: got q=%0d tc=%b expected q=%0d tc=%b", i, q0, tc0, e.q, e.tc);
        qErr++;
      end
      @(negedge clk);
    end
    checks++; if (q0 !== 14'd0) $display("[TB] FAIL full_final_q: got %0d expected 0", q0); else passes++;
    checks++; if (tcSeen != 1) $display("[TB] FAIL full_tc_count: got %0d expected 1", tcSeen); else passes++;
    checks++; if (coErr != 0 || qErr != 0) $display("[TB] FAIL full_sequence: got %0d errors expected 0", coErr + qErr); else passes++;
    checks -= (coErr + qErr);
    drive0(1'b0, 1'b0, 1'b1, 14'd0);
    @(posedge clk); #1; e = sb0.pop_front();
    checks++; if (tc0 !== 1'b0) $display("[TB] FAIL full_tc_single: got %b expected 0", tc0); else passes++;
    @(negedge clk);
  endtask

  task automatic test_clear_on_wrap;
    drive9(1'b1, 1'b0, 1'b0, 14'd9);
    @(posedge clk); #1; e = sb9.pop_front();
    checks++; if (tc9 !== 1'b0) $display("[TB] FAIL wrapclr_load_tc: got %b expected 0", tc9); else passes++;
    @(negedge clk);
    ld9 = 1'b0; ci9 = 1'b1; up9 = 1'b1;
    #1;
    checks++; if (co9 !== 1'b1) $display("[TB] FAIL wrapclr_co: got %b expected 1", co9); else passes++;
    #1 cd9 = 1'b1;
    @(posedge clk); #1;
    checks++; if (q9 !== 14'd3) $display("[TB] FAIL wrapclr_q: got %0d expected 3", q9); else passes++;
    checks++; if (tc9 !== 1'b0) $display("[TB] FAIL wrapclr_tc: got %b expected 0", tc9); else passes++;
    @(negedge clk);
    cd9 = 1'b0; ci9 = 1'b0;
    @(posedge clk); #1;
    checks++; if (tc9 !== 1'b0) $display("[TB] FAIL wrapclr_tc_after: got %b expected 0", tc9); else passes++;
    @(negedge clk);
    m9 = 14'd3;
  endtask

  task automatic test_cascade;
    ldLo = 1'b1; dLo = 14'd16382; ldHi = 1'b1; dHi = 14'd1; ciC = 1'b0;
    @(posedge clk); #1;
    checks++; if (qLo !== 14'd16382) $display("[TB] FAIL casc_load_lo: got %0d expected 16382", qLo); else passes++;
    @(negedge clk);
    ldLo = 1'b0; ldHi = 1'b0; ciC = 1'b1;
    #1;
    checks++; if (coLo !== 1'b0) $display("[TB] FAIL casc_co1: got %b expected 0", coLo); else passes++;
    @(posedge clk); #1;
    checks++; if (qHi !== 14'd1) $display("[TB] FAIL casc_hi1: got %0d expected 1", qHi); else passes++;
    @(negedge clk); #1;
    checks++; if (coLo !== 1'b1) $display("[TB] FAIL casc_co2: got %b expected 1", coLo); else passes++;
    @(posedge clk); #1;
    checks++; if (qLo !== 14'd0) $display("[TB] FAIL casc_lo2: got %0d expected 0", qLo); else passes++;
    checks++; if (qHi !== 14'd2) $display("[TB] FAIL casc_hi2: got %0d expected 2", qHi); else passes++;
    checks++; if (tcLo !== 1'b1) $display("[TB] FAIL casc_tclo: got %b expected 1", tcLo); else passes++;
    @(negedge clk);
    ciC = 1'b0;
    @(posedge clk); #1;
    checks++; if (qHi !== 14'd2) $display("[TB] FAIL casc_hi_hold: got %0d expected 2", qHi); else passes++;
    checks++; if (tcHi !== 1'b0) $display("[TB] FAIL casc_tchi: got %b expected 0", tcHi); else passes++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_down_wrap();
    test_load_above_max();
    test_clear_on_wrap();
    test_load_priority();
    test_direction_change();
    test_async_clear();
    test_count_up_full();
    test_cascade();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cnt14_updn.md
CNT14_UPDN -- requirements
Module: cnt14_updn

Interface
REQ-001 Parameter MAXVAL, default 16383, terminal value (modulus-1) for up/down wrap; legal range 1..16383.
REQ-002 Parameter INIT, default 0, value Q takes on reset; legal range 0..MAXVAL.
REQ-003 CK  input  1  single clock, all state updates on rising edge.
REQ-004 CD  input  1  asynchronous active-high clear; one clock, reset asynchronous active-high.
REQ-005 CI  input  1  count enable / carry-in; counting occurs only when CI=1.
REQ-006 LD  input  1  synchronous parallel load, priority over counting.
REQ-007 UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 D   input  14  parallel load data.
REQ-009 Q   output 14  counter state, registered.
REQ-010 CO  output 1  combinational carry/borrow-out for cascading.
REQ-011 TC  output 1  registered terminal-count pulse.

Function
REQ-012 Per rising CK edge with CD=0, priority order SHALL be: LD=1 -> Q<=D; else CI=1 -> count; else hold.
REQ-013 Load SHALL ignore CI and UP; any 14-bit D SHALL be accepted, including D>MAXVAL.
REQ-014 Up count: Q>=MAXVAL -> Q<=0 (wrap); else Q<=Q+1.
REQ-015 Down count: Q=0 -> Q<=MAXVAL (wrap); else Q<=Q-1, including Q>MAXVAL (no clamp).
REQ-016 Arithmetic SHALL be 14-bit unsigned; no intermediate value wider than 15 bits; Q never leaves 0..16383.
REQ-017 CO SHALL = CI & ~LD & ((UP & Q>=MAXVAL) | (~UP & Q==0)), i.e. asserted in the cycle whose edge will wrap.
REQ-018 CO SHALL have zero-cycle latency from CI, LD, UP and Q; no registered path.
REQ-019 TC SHALL be 1 for exactly one cycle following every edge on which a wrap occurred (registered copy of CO), else 0.
REQ-020 Load of D equal to a wrap point SHALL NOT assert TC; only counting wraps assert TC.
REQ-021 Simultaneous LD=1 and CI=1 at a wrap point: load wins, CO=0, no TC on next cycle.
REQ-022 UP change takes effect on the same edge it is sampled; no pipeline or direction-change penalty.
REQ-023 Counting latency: Q updates on the edge sampling CI=1; a sequence of N enabled edges advances Q by N modulo (MAXVAL+1) when starting in range.
REQ-024 Cascade: CO of stage k driving CI of stage k+1 (same CK) SHALL yield a correct combined counter with no extra cycle.

Reset
REQ-025 CD=1 SHALL force Q=INIT and TC=0 immediately, independent of CK.
REQ-026 While CD=1, CK edges, LD and CI SHALL have no effect; CO SHALL evaluate from Q=INIT and inputs.
REQ-027 CD deasserted mid-operation: first rising CK edge with CD=0 SHALL perform a normal LD/CI/hold update from Q=INIT.
REQ-028 CD asserted in the same cycle as a wrap SHALL suppress the following TC pulse.

Verification
REQ-029 MAXVAL=16383: CD pulse, then CI=1 UP=1 for 16384 edges -> Q steps 0..16383 then 0; CO=1 only while Q=16383; TC=1 exactly one cycle after Q returns to 0.
REQ-030 MAXVAL=9: LD D=7, then CI=1 UP=0 for 9 edges -> Q 7,6,...,0,9,8; CO=1 only at Q=0; TC one cycle after Q=9.
REQ-031 MAXVAL=9: LD D=12, CI=1 UP=1 -> Q=0 next edge, CO=1 in the load-result cycle; same with UP=0 -> Q=11, CO=0.
REQ-032 Q=16383, UP=1, CI=1, LD=1 D=100 -> Q=100, CO=0, TC stays 0.
REQ-033 Counting at Q=500, assert CD between clock edges -> Q=500 to INIT without a CK edge; release CD, CI=0 -> Q holds INIT; TC=0 throughout.
REQ-034 Two cascaded instances (MAXVAL=16383 low, MAXVAL=3 high), low preloaded 16382 -> after 2 edges low=0, high increments by exactly 1 on the wrap edge.
